cla_try: RTL and testbench
==========================

CLA_TRY -- requirements
Module: cla_try

Interface
REQ-001 Parameter REG_OUT, default 1; 1 = Sum/C/fault registered on clk (latency 1 cycle), 0 = Sum/C/fault purely combinational from inputs (reset has no effect on them).
REQ-002 clk  input  1  sole clock; rising-edge active.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 a  input  4  addend A, unsigned.
REQ-005 b  input  4  addend B, unsigned.
REQ-006 cin  input  1  carry-in to bit 0.
REQ-007 Sum  output  4  (a + b + cin) mod 16.
REQ-008 C  output  1  carry-out, bit 4 of a + b + cin.
REQ-009 fault  output  1  redundant carry-logic disagreement flag; constant 0 when FT_TMR_EN is undefined.

Function
REQ-010 Per bit i (0..3), the block SHALL form generate G[i] = a[i] & b[i] and propagate P[i] = a[i] ^ b[i].
REQ-011 Carry c0 = cin; c1..c4 SHALL each be computed in two-level sum-of-products lookahead form from G, P and cin, with no dependency on a lower computed carry (no ripple chain).
REQ-012 Sum[i] SHALL equal P[i] ^ c[i]; C SHALL equal c4.
REQ-013 Result SHALL equal the arithmetic sum of a + b + cin for all 512 input combinations.
REQ-014 The block SHALL also produce group signals GG = c4 with cin = 0 and PG = &P internally; these feed C only and are not ports.
REQ-015 With REG_OUT = 1, inputs sampled at rising edge N SHALL appear on Sum/C/fault after edge N; outputs hold between edges.
REQ-016 Boundary: a = 4'hF, b = 4'hF, cin = 1 SHALL give Sum = 4'hF, C = 1; a = b = 0, cin = 0 SHALL give Sum = 0, C = 0.
REQ-017 Boundary: full-propagate case (a ^ b = 4'hF) SHALL pass cin to C within the same combinational evaluation.
REQ-018 The block is stateless apart from the output register; no handshake, always ready.

Reset
REQ-019 With REG_OUT = 1, rst_n low SHALL force Sum = 0, C = 0, fault = 0 immediately, independent of clk.
REQ-020 Deassertion SHALL take effect at the next rising clk edge; the first post-reset edge registers the current inputs.
REQ-021 Reset asserted mid-operation SHALL discard the registered result; no partial state survives.

Configuration
REQ-022 Macro CLA_FT_TMR_EN defined: the carry-lookahead network (c1..c4) SHALL be instantiated three times, each carry bit taken as the 2-of-3 majority, and fault SHALL be 1 whenever any copy's carry vector differs from another (registered per REG_OUT).
REQ-023 CLA_FT_TMR_EN undefined: a single carry network SHALL be used and fault SHALL be tied to 0.
REQ-024 Sum/C SHALL be identical with and without the macro when no internal fault is present.

Structure
REQ-025 A shared package cla_pkg SHALL hold WIDTH = 4, a 4-bit typedef nibble_t and the majority-vote function.
REQ-026 One sub-module cla_carry_gen (inputs G, P, cin; output c[4:1]) SHALL implement the lookahead equations; cla_try instantiates it once or three times per REQ-022/023.

Verification
REQ-027 REG_OUT = 1, rst_n = 0 with a = 4'hA, b = 4'h5 -> Sum = 0, C = 0, fault = 0 without any clk edge.
REQ-028 a = 4'b0011, b = 4'b0101, cin = 0, one edge -> Sum = 4'b1000, C = 0.
REQ-029 a = 4'hF, b = 4'h1, cin = 0 -> Sum = 4'h0, C = 1; then a = 4'hF, b = 4'hF, cin = 1 -> Sum = 4'hF, C = 1.
REQ-030 a = 4'b1010, b = 4'b0101, cin = 1 (full propagate) -> Sum = 4'h0, C = 1.
REQ-031 Exhaustive 512-combination sweep (cin 0 and 1) against a + b + cin reference -> zero mismatches, fault = 0 throughout.
REQ-032 With CLA_FT_TMR_EN, force one carry-network copy's c2 stuck-at-1 on a = 4'h0, b = 4'h0, cin = 0 -> Sum = 0, C = 0, fault = 1.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the 4-bit carry-lookahead adder: width, nibble type and
// the bitwise 2-of-3 majority voter used by the CLA_FT_TMR_EN carry network.
package cla_pkg;

    localparam int WIDTH = 4;

    typedef logic [WIDTH-1:0] nibble_t;

    function automatic logic [WIDTH:1] maj3(
        input logic [WIDTH:1] x,
        input logic [WIDTH:1] y,
        input logic [WIDTH:1] z
    );
        maj3 = (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/cla_carry_gen.sv
// Two-level lookahead carry network: every carry is a flat sum-of-products of
// generate/propagate terms and cin, with no ripple dependency between carries.
module cla_carry_gen
    import cla_pkg::*;
(
    input  nibble_t    g,
    input  nibble_t    p,
    input  logic       cin,
    output logic [4:1] c
);

    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

endmodule

// File: rtl/cla_try.sv
// 4-bit carry-lookahead adder with optional output register (REG_OUT).
// Define CLA_FT_TMR_EN to triplicate the carry network with majority voting and a fault flag.
module cla_try
    import cla_pkg::*;
#(
    parameter int REG_OUT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] Sum,
    output logic       C,
    output logic       fault
);

    nibble_t    g_s;
    nibble_t    p_s;
    logic [4:1] carry_s;
    logic       gg_s;
    logic       pg_s;
    nibble_t    sum_s;
    logic       c_s;
    logic       fault_s;
    logic       c4_unused_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

`ifdef CLA_FT_TMR_EN
    logic [4:1] carry_a_s;
    logic [4:1] carry_b_s;
    logic [4:1] carry_c_s;

    cla_carry_gen u_carry_gen_a (.g(g_s), .p(p_s), .cin(cin), .c(carry_a_s));
    cla_carry_gen u_carry_gen_b (.g(g_s), .p(p_s), .cin(cin), .c(carry_b_s));
    cla_carry_gen u_carry_gen_c (.g(g_s), .p(p_s), .cin(cin), .c(carry_c_s));

    assign carry_s = maj3(carry_a_s, carry_b_s, carry_c_s);
    assign fault_s = (carry_a_s != carry_b_s) | (carry_b_s != carry_c_s);
`else
    cla_carry_gen u_carry_gen (.g(g_s), .p(p_s), .cin(cin), .c(carry_s));

    assign fault_s = 1'b0;
`endif

    // Carry-out comes from the group terms; the network's own c4 is redundant here.
    assign gg_s        = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                       | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    assign pg_s        = &p_s;
    assign c_s         = gg_s | (pg_s & cin);
    assign c4_unused_s = carry_s[4];
    assign sum_s       = p_s ^ {carry_s[3:1], cin};

    generate
        if (REG_OUT != 0) begin : gen_reg
            logic [3:0] sum_r;
            logic       c_r;
            logic       fault_r;

            // Output register; async reset clears any in-flight result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_r   <= 4'h0;
                    c_r     <= 1'b0;
                    fault_r <= 1'b0;
                end else begin
                    sum_r   <= sum_s;
                    c_r     <= c_s;
                    fault_r <= fault_s;
                end
            end

            assign Sum   = sum_r;
            assign C     = c_r;
            assign fault = fault_r;
        end else begin : gen_comb
            assign Sum   = sum_s;
            assign C     = c_s;
            assign fault = fault_s;
        end
    endgenerate

endmodule

// File: tb/tb_cla_try.sv
// Self-checking bench for cla_try (REG_OUT = 1): directed table, exhaustive sweep,
// reset sequences and, when CLA_FT_TMR_EN is defined, a stuck-carry injection.
module tb_cla_try;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       c;
        logic       flt;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] Sum;
    logic       C;
    logic       fault;

    vec_t exp_q[$];
    vec_t tbl[10];
    int   n_vec = 0;
    int   n_err = 0;

    cla_try #(.REG_OUT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .Sum   (Sum),
        .C     (C),
        .fault (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                                input logic [3:0] es, input logic ec, input logic ef);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vc; v.sum = es; v.c = ec; v.flt = ef;
        return v;
    endfunction

    task automatic check_out(input string tag);
        vec_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, got Sum=%h C=%b fault=%b", tag, Sum, C, fault);
        end else begin
            e = exp_q.pop_front();
            if (Sum !== e.sum || C !== e.c || fault !== e.flt) begin
                n_err++;
                $display("FAIL %s: a=%h b=%h cin=%b got Sum=%h C=%b fault=%b want Sum=%h C=%b fault=%b",
                         tag, e.a, e.b, e.cin, Sum, C, fault, e.sum, e.c, e.flt);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        logic [4:0] ref_sum;
        vec_t       v;

        tbl[0] = mk(4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, 1'b0);
        tbl[1] = mk(4'hF,    4'h1,    1'b0, 4'h0,    1'b1, 1'b0);
        tbl[2] = mk(4'hF,    4'hF,    1'b1, 4'hF,    1'b1, 1'b0);
        tbl[3] = mk(4'b1010, 4'b0101, 1'b1, 4'h0,    1'b1, 1'b0);
        tbl[4] = mk(4'h0,    4'h0,    1'b0, 4'h0,    1'b0, 1'b0);
        tbl[5] = mk(4'h5,    4'hA,    1'b0, 4'hF,    1'b0, 1'b0);
        tbl[6] = mk(4'h8,    4'h8,    1'b0, 4'h0,    1'b1, 1'b0);
        tbl[7] = mk(4'h7,    4'h1,    1'b1, 4'h9,    1'b0, 1'b0);
        tbl[8] = mk(4'hF,    4'h0,    1'b1, 4'h0,    1'b1, 1'b0);
        tbl[9] = mk(4'h6,    4'h9,    1'b0, 4'hF,    1'b0, 1'b0);

        // Reset asserted before any clock edge must already clear the outputs.
        rst_n = 1'b0; a = 4'hA; b = 4'h5; cin = 1'b0;
        #2;
        exp_q.push_back(mk(4'hA, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0));
        check_out("reset_no_edge");

        // Released before the first edge: that edge registers the held inputs.
        #1 rst_n = 1'b1;
        exp_q.push_back(mk(4'hA, 4'h5, 1'b0, 4'hF, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check_out("first_edge_after_reset");

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i], $sformatf("table_%0d", i));
        end

        for (int i = 0; i < 512; i++) begin
            v.a   = i[3:0];
            v.b   = i[7:4];
            v.cin = i[8];
            ref_sum = {1'b0, v.a} + {1'b0, v.b} + {4'h0, v.cin};
            v.sum = ref_sum[3:0];
            v.c   = ref_sum[4];
            v.flt = 1'b0;
            apply(v, "sweep");
        end

        // Mid-cycle reset discards the held result without waiting for a clock edge.
        apply(tbl[2], "pre_mid_reset");
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0));
        check_out("mid_reset_clear");
        @(posedge clk);
        #1;
        exp_q.push_back(mk(4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0));
        check_out("reset_held_over_edge");
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0), "after_mid_reset");

`ifdef CLA_FT_TMR_EN
        force dut.carry_a_s[2] = 1'b1;
        apply(mk(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1), "tmr_stuck_c2");
        release dut.carry_a_s[2];
        apply(mk(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0), "tmr_released");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
